fetch_buffer: RTL and testbench

- Instruction fetch front-end between the PC and the IF/ID pipeline register.
- Owns the fetch PC and issues requests to a multi-cycle instruction memory over a req/ack handshake.
- Queues each returned instruction together with its PC+4 in a small FIFO and presents the FIFO head to decode with valid/stall flow control.
- On a branch or jump redirect, flushes the queue and discards any in-flight fetch.

---
 rtl/fetch_buffer_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_buffer.sv | 122 ++++++++++++
 tb/tb_fetch_buffer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_buffer_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc_ret;
    logic [XLEN-1:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue; flush wins over push and pop.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  entry_t                   wdata,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t mem [DEPTH];
  logic [AW-1:0] rd;
  logic [AW-1:0] wr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_ap;
  logic pop_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));
  assign count  = cnt;
  assign pop_ok = pop & ~empty;
  assign cnt_ap = cnt - CW'(pop_ok);
  assign head   = empty ? '0 : mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (pop_ok) rd <= rd + AW'(1);
      if (push)   wr <= wr + AW'(1);
      cnt <= cnt_ap + CW'(push);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr] <= wdata;
  end

  // The fetch side only pushes when it reserved room beforehand.
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush)
      assert (cnt_ap < CW'(DEPTH))
      else $error("fetch_fifo overflow");
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch PC owner: issues imem requests and queues {pc+4, inst} for decode.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     redirect_i,
  input  logic [XLEN-1:0]          redirect_pc_i,
  output logic                     imem_req_o,
  output logic [XLEN-1:0]          imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [XLEN-1:0]          imem_data_i,
  output logic                     inst_valid_o,
  output logic [XLEN-1:0]          inst_o,
  output logic [XLEN-1:0]          pc_ret_o,
  input  logic                     stall_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t state;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] next_addr;
  logic [CW-1:0] cnt_ap;
  logic ack;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic space_idle;
  logic space_push;
  entry_t wdata;
  entry_t head;

  assign ack       = imem_req_o & imem_ack_i;
  assign next_addr = imem_addr_o + PC_INC;
  assign push      = (state == WAIT) & ack & ~redirect_i;
  assign pop       = inst_valid_o & ~stall_i;
  assign cnt_ap    = count_o - CW'(pop);

  assign space_idle = ~full | pop;
  assign space_push = ({1'b0, cnt_ap} + (CW+1)'(1)) < (CW+1)'(DEPTH);

  assign wdata.pc_ret = next_addr;
  assign wdata.inst   = imem_data_i;

  assign inst_valid_o = ~empty;
  assign inst_o       = head.inst;
  assign pc_ret_o     = head.pc_ret;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (redirect_i),
    .wdata (wdata),
    .head  (head),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect_i) begin
            fpc <= redirect_pc_i;
          end else if (start_i && space_idle) begin
            imem_addr_o <= fpc;
            imem_req_o  <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_i && ack) begin
            fpc        <= redirect_pc_i;
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end else if (redirect_i) begin
            // Request stays on the bus until the memory answers it.
            fpc   <= redirect_pc_i;
            state <= DROP;
          end else if (ack) begin
            fpc <= next_addr;
            if (start_i && space_push) begin
              imem_addr_o <= next_addr;
            end else begin
              imem_req_o <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_i) fpc <= redirect_pc_i;
          if (ack) begin
            imem_req_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          imem_req_o <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer with a latency-programmable memory.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        valid;
  logic [31:0] inst;
  logic [31:0] pc_ret;
  logic        stall = 1'b0;
  logic [2:0]  count;

  int chk = 0;
  int err = 0;
  int lat = 0;
  int wcnt;

  logic [63:0] sb [$];
  logic [63:0] exp_e;
  bit          dropped = 0;
  bit          p_req = 0;
  bit          p_ack = 0;
  logic [31:0] p_addr = '0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_ack_i    (ack),
    .imem_data_i   (data),
    .inst_valid_o  (valid),
    .inst_o        (inst),
    .pc_ret_o      (pc_ret),
    .stall_i       (stall),
    .count_o       (count)
  );

  // Memory: acks after lat extra cycles, data = 0x2000_0000 + addr.
  assign ack  = req && (wcnt >= lat);
  assign data = req ? 32'h2000_0000 + addr : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wcnt <= 0;
    else if (!req || ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // Scoreboard monitor: pushes at acks that decode should see, pops at pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      dropped = 0;
      p_req = 0;
      p_ack = 0;
    end else begin
      chk++;
      if (count !== 3'(sb.size()) || valid !== (sb.size() != 0)) begin
        err++;
        $display("FAIL occupancy: count=%0d valid=%0b, expected %0d", count, valid, sb.size());
      end
      if (p_req && !p_ack) begin
        chk++;
        if (!req || addr !== p_addr) begin
          err++;
          $display("FAIL addr_hold: req=%0b addr=%h, expected 1/%h", req, addr, p_addr);
        end
      end
      if (redirect) begin
        sb.delete();
        if (req) dropped = !ack;
      end else begin
        if (valid && !stall) begin
          chk++;
          if (sb.size() == 0) begin
            err++;
            $display("FAIL pop_empty: head %h/%h with nothing expected", pc_ret, inst);
          end else begin
            exp_e = sb.pop_front();
            if ({pc_ret, inst} !== exp_e) begin
              err++;
              $display("FAIL head: got %h/%h, expected %h/%h", pc_ret, inst, exp_e[63:32], exp_e[31:0]);
            end
          end
        end
        if (req && ack) begin
          if (dropped) dropped = 0;
          else sb.push_back({addr + 32'd4, 32'h2000_0000 + addr});
        end
      end
      p_req = req;
      p_ack = ack;
      p_addr = addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int i;
    start = 1'b0;
    stall = 1'b0;
    for (i = 0; i < 64 && (req || count != 0); i++) tick();
    chk++;
    if (req || count != 0) begin
      err++;
      $display("FAIL drain: req=%0b count=%0d, expected 0/0", req, count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk++;
    if (req !== 1'b0 || addr !== 32'h0 || count !== 3'd0 ||
        valid !== 1'b0 || inst !== 32'h0 || pc_ret !== 32'h0) begin
      err++;
      $display("FAIL reset: req=%0b addr=%h count=%0d valid=%0b inst=%h pc_ret=%h",
               req, addr, count, valid, inst, pc_ret);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea [3];
    logic [31:0] ei [3];
    logic [31:0] ep [3];
    ea = '{32'h4, 32'h8, 32'hC};
    ei = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008};
    ep = '{32'h4, 32'h8, 32'hC};
    do_reset();
    lat = 0;
    start = 1'b1;
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      err++;
      $display("FAIL stream_first_req: req=%0b addr=%h, expected 1/0", req, addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk++;
      if (valid !== 1'b1 || inst !== ei[i] || pc_ret !== ep[i] || addr !== ea[i]) begin
        err++;
        $display("FAIL stream_%0d: valid=%0b inst=%h pc_ret=%h addr=%h, expected 1/%h/%h/%h",
                 i, valid, inst, pc_ret, addr, ei[i], ep[i], ea[i]);
      end
    end
    drain();
  endtask

  task automatic test_stall_fill();
    do_reset();
    lat = 0;
    stall = 1'b1;
    start = 1'b1;
    repeat (8) tick();
    chk++;
    if (count !== 3'd4 || req !== 1'b0 || inst !== 32'h2000_0000 || pc_ret !== 32'h4) begin
      err++;
      $display("FAIL stall_fill: count=%0d req=%0b inst=%h pc_ret=%h, expected 4/0/20000000/4",
               count, req, inst, pc_ret);
    end
    stall = 1'b0;
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h10) begin
      err++;
      $display("FAIL stall_resume: req=%0b addr=%h, expected 1/10", req, addr);
    end
    repeat (4) tick();
    drain();
  endtask

  task automatic test_redirect_wait();
    int i;
    do_reset();
    lat = 2;
    start = 1'b1;
    for (i = 0; i < 40 && !(req && addr == 32'h8); i++) tick();
    chk++;
    if (!(req && addr == 32'h8)) begin
      err++;
      $display("FAIL rw_reach: req=%0b addr=%h, expected 1/8", req, addr);
    end
    redirect = 1'b1;
    rpc = 32'h100;
    tick();
    redirect = 1'b0;
    chk++;
    if (req !== 1'b1 || addr !== 32'h8 || count !== 3'd0 || valid !== 1'b0) begin
      err++;
      $display("FAIL rw_drop: req=%0b addr=%h count=%0d valid=%0b, expected 1/8/0/0",
               req, addr, count, valid);
    end
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h8 || ack !== 1'b1) begin
      err++;
      $display("FAIL rw_hold: req=%0b addr=%h ack=%0b, expected 1/8/1", req, addr, ack);
    end
    tick();
    chk++;
    if (req !== 1'b0 || valid !== 1'b0) begin
      err++;
      $display("FAIL rw_discard: req=%0b valid=%0b, expected 0/0", req, valid);
    end
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h100) begin
      err++;
      $display("FAIL rw_new_req: req=%0b addr=%h, expected 1/100", req, addr);
    end
    for (i = 0; i < 20 && !valid; i++) tick();
    chk++;
    if (valid !== 1'b1 || pc_ret !== 32'h104 || inst !== 32'h2000_0100) begin
      err++;
      $display("FAIL rw_head: valid=%0b pc_ret=%h inst=%h, expected 1/104/20000100",
               valid, pc_ret, inst);
    end
    drain();
  endtask

  task automatic test_redirect_ack();
    int i;
    do_reset();
    lat = 2;
    stall = 1'b1;
    start = 1'b1;
    for (i = 0; i < 40 && !(count == 3'd2 && ack); i++) tick();
    chk++;
    if (!(count == 3'd2 && ack)) begin
      err++;
      $display("FAIL ra_reach: count=%0d ack=%0b, expected 2/1", count, ack);
    end
    redirect = 1'b1;
    rpc = 32'h200;
    stall = 1'b0;
    tick();
    redirect = 1'b0;
    chk++;
    if (count !== 3'd0 || valid !== 1'b0 || req !== 1'b0) begin
      err++;
      $display("FAIL ra_flush: count=%0d valid=%0b req=%0b, expected 0/0/0", count, valid, req);
    end
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h200) begin
      err++;
      $display("FAIL ra_new_req: req=%0b addr=%h, expected 1/200", req, addr);
    end
    drain();
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 0;
    redirect = 1'b1;
    rpc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    start = 1'b1;
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'hFFFF_FFFC) begin
      err++;
      $display("FAIL wrap_req: req=%0b addr=%h, expected 1/fffffffc", req, addr);
    end
    tick();
    chk++;
    if (valid !== 1'b1 || pc_ret !== 32'h0 || inst !== 32'h1FFF_FFFC || addr !== 32'h0) begin
      err++;
      $display("FAIL wrap_head: valid=%0b pc_ret=%h inst=%h addr=%h, expected 1/0/1ffffffc/0",
               valid, pc_ret, inst, addr);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int i;
    do_reset();
    lat = 2;
    stall = 1'b1;
    start = 1'b1;
    for (i = 0; i < 40 && !(count == 3'd3 && req); i++) tick();
    chk++;
    if (!(count == 3'd3 && req)) begin
      err++;
      $display("FAIL rm_reach: count=%0d req=%0b, expected 3/1", count, req);
    end
    rst_n = 1'b0;
    #1;
    chk++;
    if (req !== 1'b0 || count !== 3'd0 || valid !== 1'b0) begin
      err++;
      $display("FAIL rm_async: req=%0b count=%0d valid=%0b, expected 0/0/0", req, count, valid);
    end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      err++;
      $display("FAIL rm_restart: req=%0b addr=%h, expected 1/0", req, addr);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    chk++;
    if (sb.size() != 0) begin
      err++;
      $display("FAIL scoreboard_left: %0d entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
